// File: rtl/stream_range_tracker.sv
// Streaming extremes tracker: collects up to FRAME_LEN samples per frame and
// presents max, min, range and count on a registered valid/ready output.
module stream_range_tracker #(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 3,
  parameter int SIGNED    = 0,
  localparam int CW       = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH:0]   out_diff,
  output logic [CW-1:0]    out_count,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH:0]   diff_q, diff_d;
  logic [CW-1:0]    count_q, count_d;

  function automatic logic greater(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) greater = ($signed(a) > $signed(b));
    else             greater = (a > b);
  endfunction

  // Widen by one bit so the signed extremes subtract without overflow.
  function automatic logic [WIDTH:0] widen(input logic [WIDTH-1:0] a);
    widen = {((SIGNED != 0) ? a[WIDTH-1] : 1'b0), a};
  endfunction

  always_comb begin
    state_d = state_q;
    max_d   = max_q;
    min_d   = min_q;
    count_d = count_q;
    if (clear) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_valid) begin
            max_d   = in_data;
            min_d   = in_data;
            count_d = CW'(1);
            state_d = (in_last || (FRAME_LEN == 1)) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            if (greater(in_data, max_q)) max_d = in_data;
            if (greater(min_q, in_data)) min_d = in_data;
            count_d = count_q + CW'(1);
            state_d = (in_last || (count_d == CW'(FRAME_LEN))) ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) state_d = EMPTY;
        end
        default: state_d = EMPTY;
      endcase
    end
    diff_d = widen(max_d) - widen(min_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      max_q   <= '0;
      min_q   <= '0;
      diff_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      min_q   <= min_d;
      diff_q  <= diff_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_max   = max_q;
  assign out_min   = min_q;
  assign out_diff  = diff_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_stream_range_tracker.sv
// Self-checking bench: an unsigned and a signed tracker share one stimulus
// stream and are compared every cycle against a frame-level reference model.
module tb_stream_range_tracker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready_u, out_valid_u, in_ready_s, out_valid_s;
  logic [7:0] max_u, min_u, max_s, min_s;
  logic [8:0] diff_u, diff_s;
  logic [1:0] count_u, count_s;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  logic       m_hold = 1'b0;
  logic [7:0] q[$];
  logic [7:0] e_umax, e_umin, e_smax, e_smin;
  logic [8:0] e_udiff, e_sdiff;
  logic [1:0] e_count;

  always #5 clk = ~clk;

  stream_range_tracker #(.WIDTH(8), .FRAME_LEN(3), .SIGNED(0)) dut_u (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_u),
    .out_max(max_u), .out_min(min_u), .out_diff(diff_u), .out_count(count_u),
    .out_valid(out_valid_u), .out_ready(out_ready));

  stream_range_tracker #(.WIDTH(8), .FRAME_LEN(3), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_data(in_data),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready_s),
    .out_max(max_s), .out_min(min_s), .out_diff(diff_s), .out_count(count_s),
    .out_valid(out_valid_s), .out_ready(out_ready));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Frame result straight from the collected samples, both interpretations.
  task automatic close_frame();
    int umax, umin, smax, smin;
    umax = q[0]; umin = q[0];
    smax = $signed(q[0]); smin = $signed(q[0]);
    foreach (q[i]) begin
      if (int'(q[i]) > umax) umax = q[i];
      if (int'(q[i]) < umin) umin = q[i];
      if (int'($signed(q[i])) > smax) smax = $signed(q[i]);
      if (int'($signed(q[i])) < smin) smin = $signed(q[i]);
    end
    e_umax = 8'(umax); e_umin = 8'(umin);
    e_smax = 8'(smax); e_smin = 8'(smin);
    e_udiff = 9'(umax - umin);
    e_sdiff = 9'(smax - smin);
    e_count = 2'(q.size());
    q.delete();
    m_hold = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_hold = 1'b0;
        q.delete();
      end else if (clear) begin
        m_hold = 1'b0;
        q.delete();
      end else if (m_hold) begin
        if (out_ready) m_hold = 1'b0;
      end else if (in_valid) begin
        q.push_back(in_data);
        if (in_last || q.size() == 3) close_frame();
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready_u", in_ready_u, !m_hold);
      chk("in_ready_s", in_ready_s, !m_hold);
      chk("out_valid_u", out_valid_u, m_hold);
      chk("out_valid_s", out_valid_s, m_hold);
      if (m_hold) begin
        chk("max_u", max_u, e_umax);
        chk("min_u", min_u, e_umin);
        chk("diff_u", diff_u, e_udiff);
        chk("count_u", count_u, e_count);
        chk("max_s", max_s, e_smax);
        chk("min_s", min_s, e_smin);
        chk("diff_s", diff_s, e_sdiff);
        chk("count_s", count_s, e_count);
      end
      if (!rst_n) begin
        chk("rst_max_u", max_u, 0);
        chk("rst_diff_s", diff_s, 0);
        chk("rst_count_u", count_u, 0);
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic last);
    int n;
    n = 0;
    while (!in_ready_u && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("send_timeout", 1, 0);
    in_data = d; in_valid = 1'b1; in_last = last;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic lit(input string tag, input logic [7:0] mx, input logic [7:0] mn,
                     input logic [8:0] df, input logic [1:0] cnt, input logic sgn);
    chk({tag, "_valid"}, sgn ? out_valid_s : out_valid_u, 1);
    chk({tag, "_max"}, sgn ? max_s : max_u, mx);
    chk({tag, "_min"}, sgn ? min_s : min_u, mn);
    chk({tag, "_diff"}, sgn ? diff_s : diff_u, df);
    chk({tag, "_count"}, sgn ? count_s : count_u, cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #2;
    chk("reset_valid", out_valid_u, 0);
    chk("reset_max", max_u, 0);
    chk("reset_min", min_s, 0);
    chk("reset_diff", diff_u, 0);
    chk("reset_count", count_u, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);
    chk("ready_after_reset", in_ready_u, 1);

    // Unsigned frame at full length
    send(8'd5, 1'b0); send(8'd200, 1'b0); send(8'd17, 1'b0);
    lit("u3", 8'd200, 8'd5, 9'd195, 2'd3, 1'b0);
    chk("u3_busy", in_ready_u, 0);
    @(posedge clk); #1;
    chk("u3_resume", in_ready_u, 1);

    // Signed extremes
    send(8'h80, 1'b0); send(8'h7F, 1'b0); send(8'h00, 1'b0);
    lit("s3", 8'h7F, 8'h80, 9'h0FF, 2'd3, 1'b1);
    lit("s3u", 8'h80, 8'h00, 9'd128, 2'd3, 1'b0);
    idle(1);

    // Early close and a single-sample frame
    send(8'd9, 1'b0); send(8'd4, 1'b1);
    lit("early", 8'd9, 8'd4, 9'd5, 2'd2, 1'b0);
    idle(1);
    send(8'd42, 1'b1);
    lit("single", 8'd42, 8'd42, 9'd0, 2'd1, 1'b0);
    idle(1);

    // Backpressure with samples offered while holding
    out_ready = 1'b0;
    send(8'd7, 1'b0); send(8'd7, 1'b0); send(8'd7, 1'b0);
    in_data = 8'd99; in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
    end
    lit("bp", 8'd7, 8'd7, 9'd0, 2'd3, 1'b0);
    chk("bp_ready", in_ready_u, 0);
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    idle(2);

    // Abort a partial frame, then a clean frame
    send(8'd250, 1'b0); send(8'd1, 1'b0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    send(8'd3, 1'b0); send(8'd8, 1'b0); send(8'd6, 1'b0);
    lit("abort", 8'd8, 8'd3, 9'd5, 2'd3, 1'b0);
    idle(1);

    // Clear while holding a result
    out_ready = 1'b0;
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd3, 1'b0);
    chk("hold_before_clear", out_valid_u, 1);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("hold_cleared", out_valid_u, 0);
    out_ready = 1'b1;
    idle(1);

    // Asynchronous reset between edges during accumulation
    send(8'd10, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_valid", out_valid_u, 0);
    chk("areset_max", max_u, 0);
    chk("areset_min", min_u, 0);
    chk("areset_count", count_u, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send(8'd10, 1'b0); send(8'd20, 1'b0); send(8'd30, 1'b0);
    lit("post_reset", 8'd30, 8'd10, 9'd20, 2'd3, 1'b0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
